// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default data width, read-side skid depth, data-word type.
// Used by the dual-clock FIFO and by both the write-side and read-side engines.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 16;
    localparam int unsigned CNT_WIDTH_DEF  = 32;
    localparam int unsigned SKID_DEPTH     = 3;
    localparam int unsigned SKID_PTR_W     = 2;

    typedef logic [FIFO_WIDTH_DEF-1:0] word_t;

    // Advance a skid-buffer pointer, wrapping from the last entry back to 0.
    function automatic logic [SKID_PTR_W-1:0] ptr_inc(input logic [SKID_PTR_W-1:0] p);
        return (p == SKID_PTR_W'(SKID_DEPTH - 1)) ? '0 : p + SKID_PTR_W'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus outgoing valid/ready stream of the read-side drain engine.
// rd_count exists only when FIFO_RD_CNT_EN is defined.
interface fifo_rd_stream_if #(
    parameter int unsigned FIFO_WIDTH = fifo_pkg::FIFO_WIDTH_DEF
`ifdef FIFO_RD_CNT_EN
    , parameter int unsigned CNT_WIDTH = fifo_pkg::CNT_WIDTH_DEF
`endif
);
    logic                  drain_en;
    logic                  empty;
    logic [FIFO_WIDTH-1:0] dout_b;
    logic                  ren_b;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
`ifdef FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0]  rd_count;
`endif

    // Drain engine side
    modport master (
        input  drain_en, empty, dout_b, m_ready,
        output ren_b, m_data, m_valid
`ifdef FIFO_RD_CNT_EN
        , output rd_count
`endif
    );

    // FIFO / consumer side
    modport slave (
        output drain_en, empty, dout_b, m_ready,
        input  ren_b, m_data, m_valid
`ifdef FIFO_RD_CNT_EN
        , input rd_count
`endif
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// 3-entry circular skid buffer absorbing the 1-cycle FIFO read latency.
// Push and pop in the same cycle leave count unchanged; ordering is strictly FIFO.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF
) (
    input  logic                  clk_b,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [SKID_PTR_W-1:0] count,
    output logic [WIDTH-1:0]      head_data
);

    logic [WIDTH-1:0]      mem [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] head;
    logic [SKID_PTR_W-1:0] tail;

    // Storage, pointers and occupancy
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            mem   <= '{default: '0};
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   count <= count + SKID_PTR_W'(1);
                2'b01:   count <= count - SKID_PTR_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for the dual-clock FIFO (clk_b domain).
// Issues ren_b against empty, captures dout_b one cycle after each accepted read into a
// 3-entry skid buffer and re-presents the words on a valid/ready stream.
// Optional build macro: FIFO_RD_CNT_EN adds the rd_count delivered-word counter.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF
`ifdef FIFO_RD_CNT_EN
    , parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
`endif
) (
    input  logic             clk_b,
    input  logic             rst,
    fifo_rd_stream_if.master bus
);

    logic                  pend;
    logic                  rd_acc;
    logic                  pop;
    logic [SKID_PTR_W-1:0] count;
    logic [2:0]            inflight;
    logic [FIFO_WIDTH-1:0] head_data;

    // Issue only from registered occupancy so m_ready never reaches ren_b combinationally
    assign inflight    = {1'b0, count} + {2'b00, pend};
    assign bus.ren_b   = !rst && bus.drain_en && !bus.empty && (inflight < 3'(SKID_DEPTH));
    assign rd_acc      = bus.ren_b && !bus.empty;
    assign bus.m_valid = (count != '0);
    assign pop         = bus.m_valid && bus.m_ready;
    assign bus.m_data  = head_data;

    // A read accepted this cycle lands on dout_b next cycle
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            pend <= rd_acc;
        end
    end

    fifo_rd_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk_b     (clk_b),
        .rst       (rst),
        .push      (pend),
        .push_data (bus.dout_b),
        .pop       (pop),
        .count     (count),
        .head_data (head_data)
    );

`ifdef FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0] rd_count_q;

    // Words delivered on the stream, wrapping naturally
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
        end else if (pop) begin
            rd_count_q <= rd_count_q + CNT_WIDTH'(1);
        end
    end

    assign bus.rd_count = rd_count_q;
`endif

    // Buffered plus in-flight words can never exceed the skid depth
    a_no_overflow: assert property (@(posedge clk_b) disable iff (rst)
        inflight <= 3'(SKID_DEPTH));

endmodule
